// File: rtl/sum_display_driver_if.sv
// Result-path bundle between the adder side and the BCD display driver.
// The master drives sum/valid; the slave reports the conversion status and result.
interface sum_display_driver_if;
  logic [13:0] sum;
  logic        valid;
  logic        busy;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        overflow;

  modport master (output sum, valid, input busy, bcd, bcd_valid, overflow);
  modport slave  (input sum, valid, output busy, bcd, bcd_valid, overflow);
endinterface

// File: rtl/sum_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a multiplexed
// common-anode 4-digit 7-segment display with leading-zero blanking.
module sum_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  sum_display_driver_if.slave  bus,
  output logic [3:0]           an,
  output logic [6:0]           seg
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic        load_sum, load_pend, shift_en, finish;
  logic        capture;
  logic [13:0] sreg;
  logic [13:0] operand;
  logic [15:0] acc;
  logic [3:0]  iter;
  logic        pending;
  logic [13:0] pend_val;
  logic [15:0] result;
  logic        result_vld;
  logic        ovf;
  logic [DIV_W-1:0] div;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic        blank;
  logic [6:0]  seg_nxt;

  function automatic logic [15:0] add3(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++)
      if (a[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A pending value left over from a DONE-cycle capture is started from IDLE
  always_comb begin
    state_nxt = state;
    load_sum  = 1'b0;
    load_pend = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid) begin
          load_sum  = 1'b1;
          state_nxt = SHIFT;
        end else if (pending) begin
          load_pend = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (iter == 4'd13) state_nxt = DONE;
      end
      DONE: begin
        finish = 1'b1;
        if (pending) begin
          load_pend = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign capture = bus.valid && (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= 1'b0;
      pend_val <= '0;
    end else if (capture) begin
      pending  <= 1'b1;
      pend_val <= bus.sum;
    end else if (load_pend || load_sum) begin
      pending  <= 1'b0;
    end
  end

  // Conversion datapath: acc:sreg shift as one 30-bit register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      operand <= '0;
      acc     <= '0;
      iter    <= '0;
    end else if (load_sum || load_pend) begin
      sreg    <= load_sum ? bus.sum : pend_val;
      operand <= load_sum ? bus.sum : pend_val;
      acc     <= '0;
      iter    <= '0;
    end else if (shift_en) begin
      acc     <= {add3(acc)[14:0], sreg[13]};
      sreg    <= {sreg[12:0], 1'b0};
      iter    <= iter + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result     <= '0;
      result_vld <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      result_vld <= finish;
      if (finish) begin
        result <= acc;
        ovf    <= (operand > 14'd9999);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.bcd       = result;
  assign bus.bcd_valid = result_vld;
  assign bus.overflow  = ovf;

  // Display scan: divider and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_W'(REFRESH_DIV - 1)) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    nib   = result[{idx, 2'b00} +: 4];
    blank = 1'b0;
    case (idx)
      2'd3:    blank = (result[15:12] == 4'd0);
      2'd2:    blank = (result[15:8]  == 8'd0);
      2'd1:    blank = (result[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    if (ovf)        seg_nxt = 7'b0111111;
    else if (blank) seg_nxt = 7'b1111111;
    else            seg_nxt = seg_decode(nib);
  end

  // Anode and segments registered together so the pair never mismatches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Bench for sum_display_driver: scoreboarded BCD results plus display scan checks.
module tb_sum_display_driver;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_8     = 7'b0000000;
  localparam logic [6:0] S_9     = 7'b0010000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] seg;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];
  bit         pend_model = 1'b0;

  sum_display_driver_if bus ();

  sum_display_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    e.bcd[15:12] = 4'((v / 1000) % 10);
    e.bcd[11:8]  = 4'((v / 100) % 10);
    e.bcd[7:4]   = 4'((v / 10) % 10);
    e.bcd[3:0]   = 4'(v % 10);
    e.ovf        = (v > 9999);
    return e;
  endfunction

  task automatic pulse(input int v);
    bus.sum   = 14'(v);
    bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic issue(input int v);
    sb.push_back(model(v));
    pulse(v);
  endtask

  task automatic issue_busy(input int v);
    if (pend_model) void'(sb.pop_back());
    sb.push_back(model(v));
    pend_model = 1'b1;
    pulse(v);
  endtask

  task automatic expect_result(input string name, input int lat);
    int   n = 0;
    bit   got = 1'b0;
    exp_t e;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (bus.bcd_valid) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no bcd_valid within 40 cycles", name);
      return;
    end
    pend_model = 1'b0;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: unexpected result %h, queue empty", name, bus.bcd);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.overflow !== e.ovf) begin
      errors++;
      $display("FAIL %s overflow: got %b, expected %b", name, bus.overflow, e.ovf);
    end
    if (!e.ovf) begin
      checks++;
      if (bus.bcd !== e.bcd) begin
        errors++;
        $display("FAIL %s bcd: got %h, expected %h", name, bus.bcd, e.bcd);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse width: bcd_valid got %b, expected 0", name, bus.bcd_valid);
    end
  endtask

  task automatic check_display(input string name, input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0);
    logic [6:0] want [4];
    logic [6:0] got  [4];
    bit         seen [4];
    bit         bad_an = 1'b0;
    want[0] = d0; want[1] = d1; want[2] = d2; want[3] = d3;
    for (int k = 0; k < 4; k++) begin
      seen[k] = 1'b0;
      got[k]  = 'x;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      case (an)
        4'b1110: begin seen[0] = 1'b1; got[0] = seg; end
        4'b1101: begin seen[1] = 1'b1; got[1] = seg; end
        4'b1011: begin seen[2] = 1'b1; got[2] = seg; end
        4'b0111: begin seen[3] = 1'b1; got[3] = seg; end
        default: bad_an = 1'b1;
      endcase
    end
    checks++;
    if (bad_an) begin
      errors++;
      $display("FAIL %s anode: non one-hot value seen, last an=%b", name, an);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!seen[k] || got[k] !== want[k]) begin
        errors++;
        $display("FAIL %s digit%0d: seg got %b (seen=%0d), expected %b", name, k, got[k], seen[k], want[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.valid = 1'b0;
    bus.sum   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== S_BLANK) begin
      errors++;
      $display("FAIL reset_display: an=%b seg=%b, expected 1111 1111111", an, seg);
    end
    checks++;
    if (bus.bcd !== 16'h0000 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bcd=%h busy=%b ovf=%b vld=%b, expected 0000 0 0 0",
               bus.bcd, bus.busy, bus.overflow, bus.bcd_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (an !== 4'b1110 || seg !== S_0) begin
      errors++;
      $display("FAIL reset_first_digit: an=%b seg=%b, expected 1110 %b", an, seg, S_0);
    end
    check_display("reset_scan", S_BLANK, S_BLANK, S_BLANK, S_0);
  endtask

  task automatic test_max_sum();
    issue(1998);
    expect_result("max_1998", 15);
    check_display("max_scan", S_1, S_9, S_9, S_8);
  endtask

  task automatic test_back_to_back();
    pend_model = 1'b0;
    issue(5);
    repeat (2) @(posedge clk);
    #1;
    issue_busy(7);
    @(posedge clk); #1;
    issue_busy(42);
    expect_result("collision_first", 10);
    expect_result("collision_second", 14);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL collision_leftover: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    issue(12345);
    expect_result("ovf_12345", 15);
    check_display("ovf_scan", S_DASH, S_DASH, S_DASH, S_DASH);
    issue(0);
    expect_result("ovf_clear_0", 15);
    check_display("zero_scan", S_BLANK, S_BLANK, S_BLANK, S_0);
  endtask

  task automatic test_boundaries();
    issue(9999);
    expect_result("bound_9999", 15);
    issue(10000);
    expect_result("bound_10000", 15);
    issue(100);
    expect_result("bound_100", 15);
    check_display("scan_100", S_BLANK, S_1, S_0, S_0);
  endtask

  task automatic test_reset_mid();
    bit saw_vld = 1'b0;
    pulse(1234);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    checks++;
    if (bus.busy !== 1'b0 || bus.bcd !== 16'h0000 || an !== 4'b1111 || seg !== S_BLANK) begin
      errors++;
      $display("FAIL mid_reset_async: busy=%b bcd=%h an=%b seg=%b, expected 0 0000 1111 1111111",
               bus.busy, bus.bcd, an, seg);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.bcd_valid) saw_vld = 1'b1;
    end
    checks++;
    if (saw_vld || bus.bcd !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_after: bcd_valid seen=%0d bcd=%h, expected 0 0000", saw_vld, bus.bcd);
    end
  endtask

  initial begin
    test_reset();
    test_max_sum();
    test_back_to_back();
    test_overflow();
    test_boundaries();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sum_display_driver.md
# sum_display_driver

Consumer end of the adder's result path. Accepts a 14-bit binary `sum` qualified by a one-cycle `valid` pulse and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, common-anode 4-digit 7-segment display. It sits between the adder submodule and the board display pins, and also exports the packed BCD result for other readers.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit during scanning. Legal range ≥ 2.
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low. Low clears all state immediately; release is synchronous to `clk` upstream.
- `sum`  in  14  binary value to display, sampled only when `valid`=1.
- `valid`  in  1  one-cycle qualifier for `sum`.
- `busy`  out  1  high while a conversion is in progress (states SHIFT, DONE).
- `bcd`  out  16  {thousands, hundreds, tens, ones}, 4 bits each; holds the last completed result.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` updates.
- `overflow`  out  1  last completed input was > 9999. Holds until the next completion.
- `an`  out  4  digit enables, active-low one-hot. `an[0]` is ones, `an[3]` is thousands.
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, `valid`=1: load `sum` into the 14-bit shift register, clear the 16-bit BCD accumulator, clear the iteration counter, go to SHIFT.
- SHIFT: each cycle, first add 3 to every accumulator nibble ≥ 5, then shift {accumulator, shift register} left by 1. Increment the counter. After the 14th iteration, go to DONE.
- DONE:
  - Copy the accumulator to `bcd`.
  - Set `overflow` = (captured operand > 9999). The operand copy is kept for this compare.
  - Pulse `bcd_valid`.
  - If pending is set, clear it, load the pending value, and go to SHIFT. Otherwise go to IDLE.
- `valid` while `busy`=1: store `sum` in a one-deep pending register and set the pending flag. A later `valid` overwrites the stored value (last-writer-wins). `valid` in the DONE cycle is also captured as pending.
- Inputs up to 16383 need 5 BCD digits. The 16-bit accumulator discards the carry out of the thousands nibble, so when `overflow`=1, `bcd` contents are don't-care.
- Display scanning:
  - A free-running divider counts 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - `an` = ~(1 << index).
  - `seg` shows the selected nibble of `bcd` through the 0–9 decoder: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading-zero blanking: thousands, hundreds and tens are blank (`seg`=1111111) when they and every higher digit are 0. Ones is never blanked.
- When `overflow`=1, every digit shows a dash (0111111).
- The display reads only the registered `bcd`/`overflow`, so it never shows intermediate conversion values.

## Timing
- Reset values:
  - FSM=IDLE, `busy`=0, `bcd`=0, `bcd_valid`=0, `overflow`=0, pending=0.
  - Divider=0, digit index=0.
  - `an`=1111, `seg`=1111111. Both are registered, so the first lit digit appears one cycle after reset release.
- Latency:
  - `valid` sampled at edge E0.
  - SHIFT iterations occur at edges E1..E14.
  - `bcd` updates and `bcd_valid` rises at edge E15 (15 cycles), high for exactly one cycle.
  - `busy` is high from after E0 until after E15.
- Back-to-back with pending: the next conversion's E0 coincides with the previous E15, so steady-state throughput is one result per 15 cycles.
- Reset low mid-conversion: the operation is aborted, the pending value is lost, no `bcd_valid` is produced, and outputs return to reset values asynchronously.
- `an`/`seg` are registered and update together one cycle after the divider wrap, so they never show a mismatched digit/anode pair.

## Test plan
- Reset: hold `reset` low, then release → `bcd`=0x0000, `busy`=0, `overflow`=0. Display scan shows "0" on `an[0]`; `an[3:1]` digits are blank.
- Max adder result: `sum`=1998 with a one-cycle `valid` → exactly 15 cycles later `bcd`=0x1998 and `bcd_valid`=1 for one cycle. With REFRESH_DIV=4, anodes 1110/1101/1011/0111 show 0000000/0010000/0010000/1111001.
- Busy collision: `sum`=5 at E0, then `sum`=7 at E3, then `sum`=42 at E5 → `bcd`=0x0005 at E15 and `bcd`=0x0042 at E30. The value 7 never appears.
- Overflow: `sum`=12345 → at completion `overflow`=1 and all four digits show 0111111. A following `sum`=0 → `overflow`=0 and the display shows "0".
- Boundary values: `sum`=9999 → 0x9999 with `overflow`=0. `sum`=10000 → `overflow`=1. `sum`=100 → digit 3 blank, digits 2/1/0 show 1/0/0.
- Reset mid-operation: drive `reset` low at E7 of a conversion of 1234, then release and wait 20 cycles → `bcd`=0x0000 and no `bcd_valid` pulse was seen.
